// File: rtl/jtag_shift_engine_if.sv
// jtag_shift_engine_if: command, TDI/TMS word and TDO word handshakes
// between a JTAG engine (slave) and the logic that drives it (master).
interface jtag_shift_engine_if #(
  parameter int DW    = 32,
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [DW-1:0]    wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine: clocked JTAG master. Runs TAP reset, TMS sequences and
// scans (optionally leaving Shift-xR on the last bit), streaming TDI/TMS bits
// in DW-bit words and returning captured TDO in DW-bit words. TCK is clk
// divided by 2*CLK_DIV; TCK is held low whenever a word stream stalls.
// DW must be at least 2.
// Optional feature macro: JTAG_SHIFT_ENGINE_IDLE_CMD_EN enables op 4
// (IDLE_CLOCKS); without it op 4 is reported as illegal.
module jtag_shift_engine #(
  parameter int DW      = 32,
  parameter int LEN_W   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  jtag_shift_engine_if.slave bus,
  output logic              busy,
  output logic              err,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WP_W  = $clog2(DW);

  localparam logic [2:0] OP_RESET     = 3'd0;
  localparam logic [2:0] OP_TMS_SEQ   = 3'd1;
  localparam logic [2:0] OP_SCAN      = 3'd2;
  localparam logic [2:0] OP_SCAN_FLIP = 3'd3;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT_WR, WAIT_RD, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx;
  logic [WP_W-1:0]  word_pos;
  logic [DIV_W-1:0] div_cnt;
  logic [DW-1:0]    wr_sr;
  logic [DW-1:0]    rd_sr;
  logic             rd_valid_q;
  logic [DW-1:0]    rd_data_q;

  logic             load_word, start_bit, div_end, last_bit, word_end;
  logic [2:0]       start_op;
  logic [LEN_W-1:0] start_len, start_idx;
  logic             start_val, tms_n, tdi_n;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef JTAG_SHIFT_ENGINE_IDLE_CMD_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  function automatic logic uses_wr(input logic [2:0] op);
    return (op == OP_TMS_SEQ) || (op == OP_SCAN) || (op == OP_SCAN_FLIP);
  endfunction

  function automatic logic uses_rd(input logic [2:0] op);
    return (op == OP_SCAN) || (op == OP_SCAN_FLIP);
  endfunction

  function automatic logic [LEN_W-1:0] eff_len(input logic [2:0] op, input logic [LEN_W-1:0] len);
    return (op == OP_RESET) ? LEN_W'(6) : len;
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = load_word;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: a bit starts only when its input word is present and
  // no captured word is waiting to be taken.
  always_comb begin
    state_n   = state;
    load_word = 1'b0;
    start_bit = 1'b0;
    div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    last_bit  = (bit_idx == len_q - LEN_W'(1));
    word_end  = (word_pos == WP_W'(DW - 1));
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (!op_legal(bus.cmd_op)) begin
            state_n = DONE;
          end else if (bus.cmd_op == OP_RESET) begin
            state_n   = LOW;
            start_bit = 1'b1;
          end else if (bus.cmd_len == '0) begin
            state_n = DONE;
          end else if (uses_wr(bus.cmd_op)) begin
            state_n = WAIT_WR;
          end else begin
            state_n   = LOW;
            start_bit = 1'b1;
          end
        end
      end
      WAIT_WR: begin
        if (bus.wr_valid && !rd_valid_q) begin
          load_word = 1'b1;
          start_bit = 1'b1;
          state_n   = LOW;
        end
      end
      LOW: begin
        if (div_end) state_n = HIGH;
      end
      HIGH: begin
        if (div_end) begin
          if (last_bit) begin
            state_n = DONE;
          end else if (uses_rd(op_q) && word_end) begin
            state_n = WAIT_RD;
          end else if (uses_wr(op_q) && word_end) begin
            state_n = WAIT_WR;
          end else begin
            state_n   = LOW;
            start_bit = 1'b1;
          end
        end
      end
      WAIT_RD: begin
        if (!rd_valid_q || bus.rd_ready) state_n = WAIT_WR;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // TMS/TDI values for the bit about to start, from the op and bit index.
  always_comb begin
    start_op  = (state == IDLE) ? bus.cmd_op : op_q;
    start_len = (state == IDLE) ? eff_len(bus.cmd_op, bus.cmd_len) : len_q;
    start_idx = (state == IDLE) ? '0 : ((state == HIGH) ? bit_idx + LEN_W'(1) : bit_idx);
    start_val = load_word ? bus.wr_data[0] : wr_sr[0];
    tms_n     = 1'b0;
    tdi_n     = 1'b0;
    case (start_op)
      OP_RESET:     tms_n = (start_idx < LEN_W'(5));
      OP_TMS_SEQ:   tms_n = start_val;
      OP_SCAN:      tdi_n = start_val;
      OP_SCAN_FLIP: begin
        tdi_n = start_val;
        tms_n = (start_idx == start_len - LEN_W'(1));
      end
      default: begin
        tms_n = 1'b0;
        tdi_n = 1'b0;
      end
    endcase
  end

  // Datapath: TCK divider, word shifters, TDO capture and word return.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      len_q      <= '0;
      bit_idx    <= '0;
      word_pos   <= '0;
      div_cnt    <= '0;
      wr_sr      <= '0;
      rd_sr      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      tck        <= 1'b0;
      tms        <= 1'b0;
      tdi        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (rd_valid_q && bus.rd_ready) rd_valid_q <= 1'b0;
      if (state == IDLE && bus.cmd_valid) begin
        op_q     <= bus.cmd_op;
        len_q    <= eff_len(bus.cmd_op, bus.cmd_len);
        bit_idx  <= '0;
        word_pos <= '0;
        rd_sr    <= '0;
        busy     <= 1'b1;
        if (!op_legal(bus.cmd_op)) err <= 1'b1;
      end
      if (load_word)      wr_sr <= bus.wr_data >> 1;
      else if (start_bit) wr_sr <= wr_sr >> 1;
      if (start_bit) begin
        tms     <= tms_n;
        tdi     <= tdi_n;
        div_cnt <= '0;
      end
      if (state == LOW) begin
        if (div_end) begin
          tck     <= 1'b1;
          div_cnt <= '0;
          if (uses_rd(op_q)) rd_sr[word_pos] <= tdo;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
      if (state == HIGH) begin
        if (div_end) begin
          tck      <= 1'b0;
          div_cnt  <= '0;
          bit_idx  <= bit_idx + LEN_W'(1);
          word_pos <= word_end ? '0 : word_pos + WP_W'(1);
          if (uses_rd(op_q) && (word_end || last_bit)) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_sr;
            rd_sr      <= '0;
          end
          if (last_bit) begin
            tms <= 1'b0;
            tdi <= 1'b0;
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
      if (state == DONE) begin
        busy <= 1'b0;
        tms  <= 1'b0;
        tdi  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb_jtag_shift_engine: directed bench for jtag_shift_engine with TDO looped
// back to TDI, pin monitors sampled on the falling clk edge and queue-driven
// word streams.
module tb_jtag_shift_engine;
  localparam int DW      = 32;
  localparam int LEN_W   = 16;
  localparam int CLK_DIV = 4;
`ifdef JTAG_SHIFT_ENGINE_IDLE_CMD_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, err, tck, tms, tdi, tdo;

  jtag_shift_engine_if #(.DW(DW), .LEN_W(LEN_W)) bus ();

  jtag_shift_engine #(.DW(DW), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .err (err),
    .tck (tck),
    .tms (tms),
    .tdi (tdi),
    .tdo (tdo)
  );

  assign tdo = tdi;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic          tms_q[$];
  logic          tdi_q[$];
  int            rise_t[$];
  int            high_q[$];
  int            cyc = 0;
  int            rise_cnt = 0;
  int            cur_high = 0;
  int            high_samples = 0;
  int            wr_pulses = 0;
  int            err_cnt = 0;
  logic          tck_prev = 1'b0;
  int            accept_mark = 0;

  // Free-running clk.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offer one command for exactly one accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [LEN_W-1:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    accept_mark   = cyc + 1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || !bus.cmd_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_mon();
    tms_q.delete();
    tdi_q.delete();
    rise_t.delete();
    high_q.delete();
    rd_q.delete();
    rise_cnt     = 0;
    high_samples = 0;
    wr_pulses    = 0;
    err_cnt      = 0;
  endtask

  function automatic logic [63:0] pack_bits(input logic q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic logic [63:0] rd_at(input int i);
    return (rd_q.size() > i) ? 64'(rd_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Write-word driver: present the queue head, pop it once handshaken.
  initial begin
    logic took;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(negedge clk);
      took = bus.wr_valid && bus.wr_ready;
      @(posedge clk); #1;
      if (took && wr_q.size() > 0) wr_q.delete(0);
      bus.wr_valid = (wr_q.size() > 0);
      bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : '0;
    end
  end

  // Pin and handshake monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tck && !tck_prev) begin
        rise_cnt++;
        tms_q.push_back(tms);
        tdi_q.push_back(tdi);
        rise_t.push_back(cyc);
      end
      if (tck) begin
        cur_high++;
        high_samples++;
      end else if (tck_prev) begin
        high_q.push_back(cur_high);
        cur_high = 0;
      end
      if (bus.wr_ready) wr_pulses++;
      if (err) err_cnt++;
      if (bus.rd_valid && bus.rd_ready) rd_q.push_back(bus.rd_data);
      tck_prev = tck;
    end
  end

  // Watchdog so a stuck engine still ends the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no completion, expected run to finish");
    $fatal(1);
  end

  // Directed test sequence.
  initial begin
    int bad;
    int n;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    checkOutput("reset_pins", {56'd0, tck, tms, tdi, bus.cmd_ready, bus.wr_ready, bus.rd_valid, busy, err},
                64'b0001_0000);
    checkOutput("reset_rd_data", 64'(bus.rd_data), 64'd0);

    // TAP reset: six bits, tms 1,1,1,1,1,0.
    clear_mon();
    applyStimulus(3'd0, '0);
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    wait_idle("reset_cmd_done", 200);
    checkOutput("reset_cmd_rises", 64'(rise_cnt), 64'd6);
    checkOutput("reset_cmd_tms", pack_bits(tms_q), 64'h1F);
    bad = 0;
    for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != 2 * CLK_DIV) bad++;
    for (int i = 0; i < high_q.size(); i++) if (high_q[i] != CLK_DIV) bad++;
    checkOutput("reset_cmd_tck_timing_bad", 64'(bad), 64'd0);
    checkOutput("reset_cmd_busy_low", 64'(busy), 64'd0);
    checkOutput("reset_cmd_no_words", 64'(wr_pulses), 64'd0);

    // 40-bit scan with looped TDO.
    clear_mon();
    wr_q.push_back(32'hDEADBEEF);
    wr_q.push_back(32'h000000A5);
    wait_cycles(2);
    applyStimulus(3'd2, 16'd40);
    wait_idle("scan40_done", 1000);
    checkOutput("scan40_first_rise", 64'((rise_t.size() > 0) ? rise_t[0] - accept_mark : -1), 64'(CLK_DIV + 1));
    checkOutput("scan40_rises", 64'(rise_cnt), 64'd40);
    checkOutput("scan40_tms", pack_bits(tms_q), 64'd0);
    checkOutput("scan40_wr_pulses", 64'(wr_pulses), 64'd2);
    checkOutput("scan40_rd_count", 64'(rd_q.size()), 64'd2);
    checkOutput("scan40_rd0", rd_at(0), 64'hDEADBEEF);
    checkOutput("scan40_rd1", rd_at(1), 64'h000000A5);

    // 8-bit scan leaving Shift-DR on the last bit.
    clear_mon();
    wr_q.push_back(32'h0000003C);
    wait_cycles(2);
    applyStimulus(3'd3, 16'd8);
    wait_idle("flip_done", 300);
    checkOutput("flip_tms", pack_bits(tms_q), 64'h80);
    checkOutput("flip_tdi", pack_bits(tdi_q), 64'h3C);
    checkOutput("flip_rd0", rd_at(0), 64'h3C);

    // TMS sequence: 5 bits of 0x15, tdi stays 0, nothing returned.
    clear_mon();
    wr_q.push_back(32'h00000015);
    wait_cycles(2);
    applyStimulus(3'd1, 16'd5);
    wait_idle("tmsseq_done", 300);
    checkOutput("tmsseq_tms", pack_bits(tms_q), 64'h15);
    checkOutput("tmsseq_tdi", pack_bits(tdi_q), 64'h0);
    checkOutput("tmsseq_rd_count", 64'(rd_q.size()), 64'd0);

    // 64-bit scan with both word streams stalled.
    clear_mon();
    bus.rd_ready = 1'b0;
    wr_q.push_back(32'h12345678);
    wait_cycles(2);
    applyStimulus(3'd2, 16'd64);
    n = 0;
    while (!bus.rd_valid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stall_rd_word1_seen", 64'(n < 600), 64'd1);
    high_samples = 0;
    wait_cycles(30);
    checkOutput("stall_rd_valid_held", 64'(bus.rd_valid), 64'd1);
    bus.rd_ready = 1'b1;
    wait_cycles(20);
    checkOutput("stall_tck_high_samples", 64'(high_samples), 64'd0);
    wr_q.push_back(32'hCAFEF00D);
    wait_idle("stall_done", 1000);
    checkOutput("stall_rises", 64'(rise_cnt), 64'd64);
    checkOutput("stall_rd_count", 64'(rd_q.size()), 64'd2);
    checkOutput("stall_rd0", rd_at(0), 64'h12345678);
    checkOutput("stall_rd1", rd_at(1), 64'hCAFEF00D);

    // Zero-length TMS sequence finishes quickly with no activity.
    clear_mon();
    applyStimulus(3'd1, 16'd0);
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("len0_within_3", 64'(n <= 3), 64'd1);
    checkOutput("len0_rises", 64'(rise_cnt), 64'd0);
    checkOutput("len0_wr_pulses", 64'(wr_pulses), 64'd0);

    // Illegal op 5.
    clear_mon();
    applyStimulus(3'd5, 16'd4);
    wait_idle("op5_done", 20);
    checkOutput("op5_err_pulses", 64'(err_cnt), 64'd1);
    checkOutput("op5_rises", 64'(rise_cnt), 64'd0);

    // Op 4: idle clocks when enabled, otherwise illegal.
    clear_mon();
    applyStimulus(3'd4, 16'd3);
    wait_idle("op4_done", 200);
    checkOutput("op4_rises", 64'(rise_cnt), IDLE_EN ? 64'd3 : 64'd0);
    checkOutput("op4_err_pulses", 64'(err_cnt), IDLE_EN ? 64'd0 : 64'd1);
    checkOutput("op4_tms", pack_bits(tms_q), 64'd0);

    // Reset in the middle of a scan, then a clean scan.
    clear_mon();
    wr_q.push_back(32'h0F0F0F0F);
    wait_cycles(2);
    applyStimulus(3'd2, 16'd32);
    n = 0;
    while (rise_cnt < 11 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("midrst_reached_bit10", 64'(n < 400), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_state", {60'd0, tck, bus.rd_valid, bus.cmd_ready, busy}, 64'b0010);
    rst = 1'b0;
    wait_cycles(1);
    clear_mon();
    wr_q.delete();
    wr_q.push_back(32'h89ABCDEF);
    wait_cycles(2);
    applyStimulus(3'd2, 16'd32);
    wait_idle("after_rst_done", 600);
    checkOutput("after_rst_rd_count", 64'(rd_q.size()), 64'd1);
    checkOutput("after_rst_rd0", rd_at(0), 64'h89ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
